// File: rtl/rms_mean_square.sv
// rms_mean_square
//   Streaming mean-of-squares accumulator feeding sqrt_unsigned in the
//   normalization datapath. Accepts one signed element per handshake,
//   squares it, accumulates 2^k squares, then divides by the length with
//   round-half-up. Adds EPS and saturates to a 20-bit unsigned result.
//
// Parameters
//   DATA_W       signed element width (2..10)
//   LEN_LOG2_MAX largest supported log2 of the vector length
//   EPS          unsigned constant added to the mean before saturation
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort of the current vector/result
//   cfg_len_log2 log2 of vector length, sampled on first element handshake
//   in_valid     element valid
//   in_ready     element ready (decoded from state only)
//   in_data      signed element
//   out_valid    result valid, held until accepted
//   out_ready    consumer ready
//   out_x        mean of squares plus EPS, saturated to 20 bits
module rms_mean_square #(
  parameter int DATA_W       = 10,
  parameter int LEN_LOG2_MAX = 12,
  parameter int EPS          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [3:0]               cfg_len_log2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [19:0]              out_x
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + LEN_LOG2_MAX;
  localparam int CNT_W = LEN_LOG2_MAX + 1;
  localparam int RES_W = (ACC_W + 2 > 21) ? ACC_W + 2 : 21;
  localparam logic [3:0]  KMAX    = 4'(LEN_LOG2_MAX);
  localparam logic [19:0] OUT_MAX = 20'hFFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [19:0]        out_x_q, out_x_d;
  logic [SQ_W-1:0]    sq_d;
  logic [SQ_W-1:0]    sq_p0;
  logic               vld_p0, vld_d;
  logic               hs_in;

  // Divide by 2^k with round half up; k=0 passes the sum through.
  function automatic logic [ACC_W:0] round_mean(input logic [ACC_W-1:0] acc,
                                                input logic [3:0]       k);
    logic [ACC_W:0] sum;
    if (k == 4'd0) begin
      return {1'b0, acc};
    end
    sum = {1'b0, acc} + ((ACC_W + 1)'(1) << (k - 4'd1));
    return sum >> k;
  endfunction

  // Add EPS and clamp to the 20-bit unsigned range.
  function automatic logic [19:0] sat_eps(input logic [ACC_W:0] mean);
    logic [RES_W-1:0] tot;
    tot = RES_W'(mean) + RES_W'(EPS);
    if (tot > RES_W'(OUT_MAX)) begin
      return OUT_MAX;
    end
    return tot[19:0];
  endfunction

  function automatic logic [3:0] clamp_k(input logic [3:0] c);
    return (c > KMAX) ? KMAX : c;
  endfunction

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_x     = out_x_q;
  assign hs_in     = in_valid && in_ready;

  // Operands are sign-extended first so the product is the exact square.
  assign sq_d = SQ_W'(in_data) * SQ_W'(in_data);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_x_d = out_x_q;
    vld_d   = hs_in && !clear;

    if (vld_p0) begin
      acc_d = acc_q + ACC_W'(sq_p0);
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          k_d     = clamp_k(cfg_len_log2);
          cnt_d   = CNT_W'(1);
          state_d = (k_d == 4'd0) ? S_DRAIN : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == (CNT_W'(1) << k_q)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last square lands in acc one cycle after its handshake;
        // once the square register is empty acc holds the final sum.
        if (!vld_p0) begin
          out_x_d = sat_eps(round_mean(acc_q, k_q));
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An output handshake coinciding with clear has already completed
    // above; clear then only forces the clean-IDLE outcome.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      out_x_d = out_x_q;
    end
  end

  // Stage p0: square register; control side reset, data side free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      vld_p0  <= 1'b0;
      acc_q   <= '0;
      out_x_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      vld_p0  <= vld_d;
      acc_q   <= acc_d;
      out_x_q <= out_x_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs_in) begin
      sq_p0 <= sq_d;
    end
  end

endmodule
